pipeline_stall_controller: RTL and testbench

Central stall/flush sequencer for the five-stage pipeline. It sits beside the stage buffers (pc, if/id, id/ex, ex/mem, mem/wb) and drives a per-stage stall vector that every buffer samples. It resolves three request sources in priority order: flush, EX-stage stall, ID-stage stall. It also owns the cycle counter that holds the id/ex buffer while a multi-cycle EX operation completes.

---
 rtl/pipeline_stall_controller.sv | 117 +++++++++++
 tb/tb_pipeline_stall_controller.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/pipeline_stall_controller.sv
// Stall/flush sequencer for the five-stage pipeline. It resolves flush, EX
// stall and ID stall requests into a per-stage hold vector, sequences
// multi-cycle EX operations, and counts stalled cycles with saturation.
module pipeline_stall_controller #(
  parameter int unsigned MULTI_LATENCY = 4,
  parameter int unsigned CNT_WIDTH     = 4,
  parameter int unsigned PERF_WIDTH    = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  id_stall_request,
  input  logic                  ex_multi_start,
  input  logic                  ex_stall_request,
  input  logic                  flush_request,
  output logic [5:0]            stall,
  output logic                  flush,
  output logic                  ex_busy,
  output logic                  ex_multi_done,
  output logic [PERF_WIDTH-1:0] stall_cycles
);

  localparam logic [5:0] LP_STALL_EX   = 6'b001111;
  localparam logic [5:0] LP_STALL_ID   = 6'b000111;
  localparam logic [5:0] LP_STALL_NONE = 6'b000000;

  // A latency of 2 loads zero, so the cycle after the start is the completion cycle.
  localparam logic [CNT_WIDTH-1:0] LP_LOAD = CNT_WIDTH'(MULTI_LATENCY - 2);

  typedef enum logic {
    S_IDLE,
    S_BUSY
  } state_t;

  state_t                r_state;
  logic [CNT_WIDTH-1:0]  r_count;
  logic [PERF_WIDTH-1:0] r_stall_cycles;

  logic w_count_zero;
  logic w_multi_hold;
  logic w_ex_stall;
  logic w_complete;

  assign w_count_zero = (r_count == '0);
  // The multi-cycle op holds EX on its start cycle and while the counter runs.
  assign w_multi_hold = ((r_state == S_IDLE) && ex_multi_start) ||
                        ((r_state == S_BUSY) && !w_count_zero);
  assign w_ex_stall   = ex_stall_request || w_multi_hold;
  // Completion is only reported once no other EX stall is holding the result.
  assign w_complete   = (r_state == S_BUSY) && w_count_zero && !ex_stall_request;

  // Priority resolution of the stall vector, flush and done pulse.
  always_comb begin
    stall         = LP_STALL_NONE;
    flush         = 1'b0;
    ex_multi_done = 1'b0;
    if (reset) begin
      stall         = LP_STALL_NONE;
      flush         = 1'b0;
      ex_multi_done = 1'b0;
    end else if (flush_request) begin
      flush = 1'b1;
    end else if (w_ex_stall) begin
      stall = LP_STALL_EX;
    end else if (id_stall_request) begin
      stall = LP_STALL_ID;
    end else begin
      stall = LP_STALL_NONE;
    end
    if (!reset && !flush_request && w_complete) begin
      ex_multi_done = 1'b1;
    end
  end

  assign ex_busy      = (r_state == S_BUSY);
  assign stall_cycles = r_stall_cycles;

  // Multi-cycle EX sequencer: start loads the counter, BUSY counts down, flush abandons.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_count <= '0;
    end else if (flush_request) begin
      r_state <= S_IDLE;
      r_count <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (ex_multi_start) begin
            r_state <= S_BUSY;
            r_count <= LP_LOAD;
          end
        end
        S_BUSY: begin
          if (!w_count_zero) begin
            r_count <= r_count - 1'b1;
          end else if (!ex_stall_request) begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_count <= '0;
        end
      endcase
    end
  end

  // Saturating count of cycles in which any stage is held.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_stall_cycles <= '0;
    end else if ((stall != LP_STALL_NONE) && (r_stall_cycles != '1)) begin
      r_stall_cycles <= r_stall_cycles + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Directed bench for pipeline_stall_controller with default parameters.
module tb_pipeline_stall_controller;

  logic        clock;
  logic        reset;
  logic        id_stall_request;
  logic        ex_multi_start;
  logic        ex_stall_request;
  logic        flush_request;
  logic [5:0]  stall;
  logic        flush;
  logic        ex_busy;
  logic        ex_multi_done;
  logic [15:0] stall_cycles;

  int n_total;
  int n_bad;

  pipeline_stall_controller #(
    .MULTI_LATENCY(4),
    .CNT_WIDTH(4),
    .PERF_WIDTH(16)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .id_stall_request (id_stall_request),
    .ex_multi_start   (ex_multi_start),
    .ex_stall_request (ex_stall_request),
    .flush_request    (flush_request),
    .stall            (stall),
    .flush            (flush),
    .ex_busy          (ex_busy),
    .ex_multi_done    (ex_multi_done),
    .stall_cycles     (stall_cycles)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic r, input logic id, input logic ms,
                       input logic es, input logic fl);
    reset            = r;
    id_stall_request = id;
    ex_multi_start   = ms;
    ex_stall_request = es;
    flush_request    = fl;
    #1;
  endtask

  initial begin
    n_total = 0;
    n_bad   = 0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();

    // Reset held two cycles with every request high.
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    chk("rst1_stall", 32'(stall), 32'h00);
    chk("rst1_flush", 32'(flush), 32'h0);
    chk("rst1_done",  32'(ex_multi_done), 32'h0);
    tick();
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    chk("rst2_stall", 32'(stall), 32'h00);
    chk("rst2_flush", 32'(flush), 32'h0);
    chk("rst2_done",  32'(ex_multi_done), 32'h0);
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("rst_perf", 32'(stall_cycles), 32'd0);
    chk("rst_busy", 32'(ex_busy), 32'h0);
    chk("idle_stall", 32'(stall), 32'h00);
    tick();

    // Multi-cycle op, latency 4, no other stalls.
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("m1_stall", 32'(stall), 32'h0F);
    chk("m1_busy",  32'(ex_busy), 32'h0);
    chk("m1_done",  32'(ex_multi_done), 32'h0);
    tick();
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("m2_stall", 32'(stall), 32'h0F);
    chk("m2_busy",  32'(ex_busy), 32'h1);
    chk("m2_done",  32'(ex_multi_done), 32'h0);
    tick();
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("m3_stall", 32'(stall), 32'h0F);
    chk("m3_busy",  32'(ex_busy), 32'h1);
    tick();
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("m4_stall", 32'(stall), 32'h00);
    chk("m4_busy",  32'(ex_busy), 32'h1);
    chk("m4_done",  32'(ex_multi_done), 32'h1);
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("m5_busy",  32'(ex_busy), 32'h0);
    chk("m5_done",  32'(ex_multi_done), 32'h0);
    chk("m5_perf",  32'(stall_cycles), 32'd3);
    tick();

    // Same op with an EX stall in the completion cycle.
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("x2_stall", 32'(stall), 32'h0F);
    tick();
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("x4_stall", 32'(stall), 32'h0F);
    chk("x4_done",  32'(ex_multi_done), 32'h0);
    chk("x4_busy",  32'(ex_busy), 32'h1);
    tick();
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("x5_stall", 32'(stall), 32'h00);
    chk("x5_done",  32'(ex_multi_done), 32'h1);
    chk("x5_busy",  32'(ex_busy), 32'h1);
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("x6_busy",  32'(ex_busy), 32'h0);
    chk("x6_perf",  32'(stall_cycles), 32'd4);
    tick();

    // Flush in cycle 2 of a multi-cycle op.
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("f2_flush", 32'(flush), 32'h1);
    chk("f2_stall", 32'(stall), 32'h00);
    chk("f2_done",  32'(ex_multi_done), 32'h0);
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("f3_busy",  32'(ex_busy), 32'h0);
    chk("f3_done",  32'(ex_multi_done), 32'h0);
    chk("f3_flush", 32'(flush), 32'h0);
    chk("f3_perf",  32'(stall_cycles), 32'd5);
    tick();

    // Flush and multi start together in IDLE: flush wins.
    drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    chk("fs_flush", 32'(flush), 32'h1);
    chk("fs_stall", 32'(stall), 32'h00);
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("fs_busy",  32'(ex_busy), 32'h0);
    tick();

    // ID stall alone for three cycles, then combined with EX stall.
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      chk($sformatf("id%0d_stall", i), 32'(stall), 32'h07);
      tick();
    end
    drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("idex_stall", 32'(stall), 32'h0F);
    chk("idex_busy",  32'(ex_busy), 32'h0);
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("idex_perf", 32'(stall_cycles), 32'd9);
    tick();

    // Saturation of the stall-cycle counter.
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 65534; i++) tick();
    chk("sat_pre",  32'(stall_cycles), 32'd65534);
    for (int i = 0; i < 6; i++) tick();
    chk("sat_hold", 32'(stall_cycles), 32'd65535);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("sat_idle", 32'(stall_cycles), 32'd65535);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
